// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths and FSM state encoding for the sequential divider
package div_pkg;

   localparam int DIV_DW = 6;
   localparam int DIV_VW = 3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;
   localparam logic [1:0] ST_ZERO = 2'd3;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step
   import div_pkg::*;
#(
   parameter int VW = DIV_VW
) (
   input  logic [VW-1:0] rem_in,
   input  logic          bit_in,
   input  logic [VW-1:0] div,
   output logic [VW-1:0] rem_out,
   output logic          q_bit
);

   logic [VW:0] rem_t;

   assign rem_t = {rem_in, bit_in};
   assign q_bit = (rem_t >= {1'b0, div});
   // The difference is below div, so the low VW bits of the subtraction are exact.
   assign rem_out = q_bit ? (rem_t[VW-1:0] - div) : rem_t[VW-1:0];

endmodule

// File: rtl/div6by3_seq.sv
// rtl/div6by3_seq.sv - sequential restoring divider, one quotient bit per clock
module div6by3_seq
   import div_pkg::*;
#(
   parameter int DW = DIV_DW,
   parameter int VW = DIV_VW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] A,
   input  logic [VW-1:0] B,
   output logic [DW-1:0] q,
   output logic [VW-1:0] r,
   output logic          busy,
   output logic          done,
   output logic          dbz
);

   localparam int CW = $clog2(DW);

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] shift_q, shift_d;
   logic [VW-1:0] div_q, div_d;
   logic [VW-1:0] rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] q_q, q_d;
   logic [VW-1:0] r_q, r_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          dbz_q, dbz_d;

   logic [VW-1:0] step_rem;
   logic          step_q;

   div_step #(.VW(VW)) u_step (
      .rem_in  (rem_q),
      .bit_in  (shift_q[DW-1]),
      .div     (div_q),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      div_d   = div_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               busy_d = 1'b1;
               if (B != '0) begin
                  state_d = ST_RUN;
                  shift_d = A;
                  div_d   = B;
                  rem_d   = '0;
                  cnt_d   = CW'(DW - 1);
               end else begin
                  state_d = ST_ZERO;
               end
            end
         end
         ST_RUN: begin
            // Dividend bits leave at the MSB while quotient bits fill the LSB.
            shift_d = {shift_q[DW-2:0], step_q};
            rem_d   = step_rem;
            if (cnt_q == '0) begin
               state_d = ST_FIN;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_FIN: begin
            q_d     = shift_q;
            r_d     = rem_q;
            dbz_d   = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         ST_ZERO: begin
            q_d     = '1;
            r_d     = '0;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         div_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign q    = q_q;
   assign r    = r_q;
   assign busy = busy_q;
   assign done = done_q;
   assign dbz  = dbz_q;

endmodule

// File: tb/tb_div6by3_seq.sv
// tb/tb_div6by3_seq.sv - scoreboard bench for div6by3_seq
module tb_div6by3_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [5:0] A;
   logic [2:0] B;
   logic [5:0] q;
   logic [2:0] r;
   logic       busy;
   logic       done;
   logic       dbz;

   typedef struct {
      int a;
      int b;
      int eq;
      int er;
      int edbz;
   } exp_t;

   exp_t sb[$];
   int   n_chk;
   int   n_fail;

   div6by3_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .q     (q),
      .r     (r),
      .busy  (busy),
      .done  (done),
      .dbz   (dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_exp(input int a, input int b);
      exp_t e;
      e.a = a;
      e.b = b;
      if (b == 0) begin
         e.eq = 63;
         e.er = 0;
         e.edbz = 1;
      end else begin
         e.eq = a / b;
         e.er = a % b;
         e.edbz = 0;
      end
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         check("done_without_busy", int'(busy), 0);
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("q", int'(q), e.eq);
            check("r", int'(r), e.er);
            check("dbz", int'(dbz), e.edbz);
            if (e.b != 0) begin
               check("q_times_b_plus_r", int'(q) * e.b + int'(r), e.a);
               check("r_below_b", int'(int'(r) < e.b), 1);
            end
         end
      end
   end

   // poke > 0 re-pulses start with fresh operands that many cycles into the run.
   task automatic run_op(input int a, input int b, input int poke);
      int lat;
      int busy_low;
      int exp_lat;
      @(negedge clk);
      A = 6'(a);
      B = 3'(b);
      start = 1'b1;
      push_exp(a, b);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_start", int'(busy), 1);
      exp_lat = (b == 0) ? 1 : 7;
      lat = 0;
      busy_low = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         if (i == poke) begin
            start = 1'b1;
            A = 6'($urandom);
            B = 3'($urandom);
         end
         @(posedge clk);
         #1;
         if (i == poke) start = 1'b0;
         if (done) lat = i;
         else if (!busy) busy_low++;
      end
      check("latency", lat, exp_lat);
      check("busy_held", busy_low, 0);
   endtask

   initial begin
      int dones;
      int c;
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b0;
      start = 1'b0;
      A = '0;
      B = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_q", int'(q), 0);
      check("rst_r", int'(r), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_dbz", int'(dbz), 0);
      rst_n = 1'b1;

      run_op(20, 3, 0);
      run_op(63, 7, 0);
      run_op(30, 5, 0);
      run_op(5, 7, 0);
      run_op(42, 0, 0);
      run_op(49, 7, 0);
      run_op(20, 3, 3);
      run_op(61, 6, 1);

      @(negedge clk);
      A = 6'd20;
      B = 3'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort_q", int'(q), 0);
      check("abort_r", int'(r), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_dbz", int'(dbz), 0);
      rst_n = 1'b1;
      dones = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      check("no_done_after_abort", dones, 0);
      run_op(55, 4, 0);

      for (int n = 0; n < 40; n++) begin
         int a;
         int b;
         a = int'($urandom_range(0, 63));
         b = int'($urandom_range(0, 7));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         run_op(a, b, (b != 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : 0);
      end

      @(negedge clk);
      A = 6'd0;
      B = 3'd1;
      start = 1'b1;
      push_exp(0, 1);
      for (int idx = 1; idx <= 448; idx++) begin
         c = 0;
         do begin
            @(posedge clk);
            #1;
            c++;
         end while (!done && c < 20);
         if (!done) begin
            check("back_to_back_timeout", c, 7);
            break;
         end
         if (idx < 448) begin
            A = 6'(idx / 7);
            B = 3'(idx % 7 + 1);
            push_exp(idx / 7, idx % 7 + 1);
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;

      repeat (12) @(posedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
